multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: TIMEOUT_W, default 8, width of the memory-wait counter; a timeout occurs after 2^TIMEOUT_W-1 wait cycles.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 opcode  in  7  instruction[6:0] from the IR; stable from DECODE until retire.
REQ-005 branch_taken  in  1  comparator result for the current BRANCH; sampled in EXEC.
REQ-006 mem_ready  in  1  memory completes the access in the cycle it is high while mem_req=1.
REQ-007 mem_req  out  1  memory access request.
REQ-008 mem_we  out  1  store strobe; valid only while mem_req=1.
REQ-009 ir_we  out  1  IR load enable.
REQ-010 pc_we  out  1  PC update enable; its assertion marks retire.
REQ-011 pc_sel  out  2  next-PC select: 00 pc+4, 01 pc+imm, 10 ALU result with bit0 cleared.
REQ-012 reg_we  out  1  register-file write enable.
REQ-013 wb_sel  out  2  write-back select: 00 ALU, 01 load data, 10 pc+4, 11 imm.
REQ-014 alu_src_a  out  1  ALU A operand select: 0 rs1, 1 PC.
REQ-015 alu_src_b  out  1  ALU B operand select: 0 rs2, 1 imm.
REQ-016 instret  out  1  one-cycle pulse per retired instruction (equals pc_we).
REQ-017 halted  out  1  high while in HALT.
REQ-018 bus_err  out  1  sticky; set on memory timeout.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT; outputs are decoded from state and opcode, and any output not listed for a state is 0.
REQ-020 IDLE SHALL drive all outputs 0 and SHALL go to FETCH on the next edge.
REQ-021 FETCH SHALL hold mem_req=1 and mem_we=0 until mem_ready; in the mem_ready cycle it SHALL assert ir_we and go to DECODE.
REQ-022 DECODE SHALL last one cycle and go to EXEC.
REQ-023 EXEC SHALL set alu_src_b=1 for OP-IMM, LOAD, STORE and JALR, alu_src_a=1 for AUIPC, and go to MEM for LOAD/STORE or WB for OP, OP-IMM, LUI, AUIPC, JAL and JALR.
REQ-024 For BRANCH, EXEC SHALL assert pc_we with pc_sel=01 if branch_taken else 00, then go to FETCH.
REQ-025 MEM SHALL hold mem_req=1, mem_we=1 for STORE, and alu_src_b=1 until mem_ready; STORE then retires in that cycle (pc_we, pc_sel=00) and goes to FETCH, while LOAD goes to WB.
REQ-026 WB SHALL assert reg_we and pc_we for one cycle, then go to FETCH.
REQ-027 WB selects: OP, OP-IMM and AUIPC use wb_sel=00; LOAD uses 01; JAL and JALR use 10; LUI uses 11; pc_sel=01 for JAL, 10 for JALR, else 00; operand selects are held as in EXEC.
REQ-028 Zero-wait latency in cycles SHALL be: BRANCH 3, STORE 4, ALU/LUI/AUIPC/JAL/JALR 4, LOAD 5; each mem_ready-low cycle adds one.
REQ-029 The wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_req=1 with mem_ready=0.
REQ-030 When the counter reaches 2^TIMEOUT_W-1 with mem_ready still 0, the FSM SHALL set bus_err and go to HALT; mem_ready in that same cycle wins, with no error.
REQ-031 HALT SHALL drive halted=1 and all other control outputs 0, and SHALL be left only by reset.
REQ-032 mem_req SHALL never drop while mem_ready=0 inside FETCH or MEM, except on reset or timeout.

Reset
REQ-033 rst_n=0 at a clock edge SHALL force IDLE, clear the wait counter and clear bus_err, from any state including mid-access.
REQ-034 While in reset and in the first cycle after release, every output SHALL be 0.

Configuration
REQ-035 With ILLEGAL_OPCODE_TRAP_EN defined, an opcode outside the RV32I set (including FENCE and SYSTEM) in EXEC SHALL go to HALT without pc_we.
REQ-036 Without ILLEGAL_OPCODE_TRAP_EN, such an opcode SHALL retire as a NOP in EXEC (pc_we=1, pc_sel=00, reg_we=0) and go to FETCH.

Verification
REQ-037 ADDI (0010011), mem_ready tied 1 -> states FETCH, DECODE, EXEC, WB; reg_we=1 and wb_sel=00 in WB; instret pulses once in cycle 4.
REQ-038 LW (0000011), mem_ready low 2 cycles in MEM -> mem_req held 3 cycles in MEM; WB asserts wb_sel=01; total latency 7.
REQ-039 BEQ (1100011), branch_taken=1 -> pc_we with pc_sel=01 in EXEC; with branch_taken=0 -> pc_sel=00; 3 cycles each.
REQ-040 TIMEOUT_W=3, mem_ready held 0 in FETCH -> after 7 wait cycles bus_err=1, halted=1, mem_req=0; rst_n low one edge -> IDLE with bus_err=0.
REQ-041 opcode 7'b1111111 -> halted=1 and no pc_we with ILLEGAL_OPCODE_TRAP_EN; without it, pc_we=1, reg_we=0 and the FSM returns to FETCH.
REQ-042 rst_n asserted during a STORE in MEM with mem_ready=0 -> next cycle mem_req=0, mem_we=0, state IDLE, and no retire.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I datapath: fetch, decode, execute, memory and write-back sequencing.
// Optional build macro ILLEGAL_OPCODE_TRAP_EN: non-RV32I opcodes halt instead of retiring as a NOP.
module multicycle_ctrl #(
    parameter int TIMEOUT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic       instret,
    output logic       halted,
    output logic       bus_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] MEM    = 3'd4;
    localparam logic [2:0] WB     = 3'd5;
    localparam logic [2:0] HALT   = 3'd6;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Last counter value at which a still-pending access is allowed one more try.
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 bus_err_q;

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic is_load, is_store, is_opimm, is_op, is_legal, is_wb_op;
    logic op_sel_a, op_sel_b;
    logic mem_wait, timeout;

    logic       mem_req_c, mem_we_c, ir_we_c, pc_we_c, reg_we_c;
    logic       alu_src_a_c, alu_src_b_c, halted_c;
    logic [1:0] pc_sel_c, wb_sel_c;

    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_opimm  = (opcode == OPC_OPIMM);
    assign is_op     = (opcode == OPC_OP);

    assign is_wb_op = is_op | is_opimm | is_lui | is_auipc | is_jal | is_jalr;
    assign is_legal = is_wb_op | is_branch | is_load | is_store;

    // Operand selects are set in EXEC and held through MEM/WB so the ALU result stays valid.
    assign op_sel_a = is_auipc;
    assign op_sel_b = is_opimm | is_load | is_store | is_jalr;

    assign mem_req_c = (state == FETCH) || (state == MEM);
    assign mem_wait  = mem_req_c && !mem_ready;
    assign timeout   = mem_wait && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   state_nxt = FETCH;
            FETCH: begin
                if (mem_ready)    state_nxt = DECODE;
                else if (timeout) state_nxt = HALT;
            end
            DECODE: state_nxt = EXEC;
            EXEC: begin
                if (is_load || is_store) state_nxt = MEM;
                else if (is_wb_op)       state_nxt = WB;
                else if (is_branch)      state_nxt = FETCH;
                else begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
                    state_nxt = HALT;
`else
                    state_nxt = FETCH;
`endif
                end
            end
            MEM: begin
                if (mem_ready)    state_nxt = is_store ? FETCH : WB;
                else if (timeout) state_nxt = HALT;
            end
            WB:     state_nxt = FETCH;
            HALT:   state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // The wait counter restarts on every state change, so each access starts counting from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (mem_wait)
                wait_cnt <= wait_cnt + 1'b1;
            if (timeout)
                bus_err_q <= 1'b1;
        end
    end

    always_comb begin
        mem_we_c    = 1'b0;
        ir_we_c     = 1'b0;
        pc_we_c     = 1'b0;
        pc_sel_c    = 2'b00;
        reg_we_c    = 1'b0;
        wb_sel_c    = 2'b00;
        alu_src_a_c = 1'b0;
        alu_src_b_c = 1'b0;
        halted_c    = 1'b0;
        case (state)
            FETCH: ir_we_c = mem_ready;
            EXEC: begin
                alu_src_a_c = op_sel_a;
                alu_src_b_c = op_sel_b;
                if (is_branch) begin
                    pc_we_c  = 1'b1;
                    pc_sel_c = branch_taken ? 2'b01 : 2'b00;
                end else if (!is_legal) begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
                    pc_we_c = 1'b0;
`else
                    pc_we_c = 1'b1;
`endif
                end
            end
            MEM: begin
                mem_we_c    = is_store;
                alu_src_b_c = 1'b1;
                pc_we_c     = is_store && mem_ready;
            end
            WB: begin
                reg_we_c    = 1'b1;
                pc_we_c     = 1'b1;
                alu_src_a_c = op_sel_a;
                alu_src_b_c = op_sel_b;
                if (is_load)                wb_sel_c = 2'b01;
                else if (is_jal || is_jalr) wb_sel_c = 2'b10;
                else if (is_lui)            wb_sel_c = 2'b11;
                if (is_jal)       pc_sel_c = 2'b01;
                else if (is_jalr) pc_sel_c = 2'b10;
            end
            HALT:    halted_c = 1'b1;
            default: ;
        endcase
    end

    // Gating with rst_n keeps every output quiet for the whole reset window, not just after the edge.
    assign mem_req   = rst_n & mem_req_c;
    assign mem_we    = rst_n & mem_we_c;
    assign ir_we     = rst_n & ir_we_c;
    assign pc_we     = rst_n & pc_we_c;
    assign instret   = rst_n & pc_we_c;
    assign pc_sel    = {2{rst_n}} & pc_sel_c;
    assign reg_we    = rst_n & reg_we_c;
    assign wb_sel    = {2{rst_n}} & wb_sel_c;
    assign alu_src_a = rst_n & alu_src_a_c;
    assign alu_src_b = rst_n & alu_src_b_c;
    assign halted    = rst_n & halted_c;
    assign bus_err   = rst_n & bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl (TIMEOUT_W=3); expected outputs are hand-derived per cycle.
// Output vector order: mem_req mem_we ir_we pc_we pc_sel reg_we wb_sel alu_a alu_b instret halted bus_err.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req, mem_we, ir_we, pc_we, reg_we;
    logic [1:0] pc_sel, wb_sel;
    logic       alu_src_a, alu_src_b, instret, halted, bus_err;

    int vectors;
    int miscompares;

    // Stimulus codes {rst_n, mem_ready, branch_taken}
    localparam logic [2:0] SR = 3'b000;
    localparam logic [2:0] SW = 3'b100;
    localparam logic [2:0] SY = 3'b110;
    localparam logic [2:0] ST = 3'b111;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_ADD  = 7'b0110011;

    logic [13:0] ZZ, FR, FW, HL, HE;

    multicycle_ctrl #(.TIMEOUT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .instret(instret),
        .halted(halted), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] mk(input logic mreq, input logic mwe, input logic irwe,
                                       input logic pcwe, input logic [1:0] psel, input logic rwe,
                                       input logic [1:0] wsel, input logic a, input logic b,
                                       input logic hlt, input logic berr);
        return {mreq, mwe, irwe, pcwe, psel, rwe, wsel, a, b, pcwe, hlt, berr};
    endfunction

    function automatic logic [13:0] outs();
        return {mem_req, mem_we, ir_we, pc_we, pc_sel, reg_we, wb_sel,
                alu_src_a, alu_src_b, instret, halted, bus_err};
    endfunction

    task automatic cyc(input logic [2:0] s, input logic [6:0] op);
        @(negedge clk);
        rst_n        = s[2];
        mem_ready    = s[1];
        branch_taken = s[0];
        opcode       = op;
        #1;
    endtask

    task automatic test_reset();
        logic [2:0]  s[$];
        logic [13:0] e[$];
        s = '{SR, SR, SY, SY, SY};
        e = '{ZZ, ZZ, ZZ, FR, ZZ};
        for (int i = 0; i < s.size(); i++) begin
            cyc(s[i], OP_ADD);
            vectors++;
            if (outs() !== e[i]) begin
                miscompares++;
                $display("[TB] FAIL reset[%0d]: got %b, expected %b", i, outs(), e[i]);
            end
        end
    endtask

    task automatic test_alu_class();
        logic [6:0]  ops[6];
        logic [13:0] ex[6];
        logic [13:0] wb[6];
        logic [2:0]  s[$];
        logic [13:0] e[$];
        ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
        ex  = '{ZZ, mk(0,0,0,0,2'b00,0,2'b00,0,1,0,0), ZZ, mk(0,0,0,0,2'b00,0,2'b00,1,0,0,0),
                ZZ, mk(0,0,0,0,2'b00,0,2'b00,0,1,0,0)};
        wb  = '{mk(0,0,0,1,2'b00,1,2'b00,0,0,0,0), mk(0,0,0,1,2'b00,1,2'b00,0,1,0,0),
                mk(0,0,0,1,2'b00,1,2'b11,0,0,0,0), mk(0,0,0,1,2'b00,1,2'b00,1,0,0,0),
                mk(0,0,0,1,2'b01,1,2'b10,0,0,0,0), mk(0,0,0,1,2'b10,1,2'b10,0,1,0,0)};
        for (int k = 0; k < 6; k++) begin
            s = '{SR, SY, SY, SY, SY, SY, SY};
            e = '{ZZ, ZZ, FR, ZZ, ex[k], wb[k], FR};
            for (int i = 0; i < s.size(); i++) begin
                cyc(s[i], ops[k]);
                vectors++;
                if (outs() !== e[i]) begin
                    miscompares++;
                    $display("[TB] FAIL alu op=%b [%0d]: got %b, expected %b", ops[k], i, outs(), e[i]);
                end
            end
        end
    endtask

    task automatic test_load_wait();
        logic [2:0]  s[$];
        logic [13:0] e[$];
        logic [13:0] eb, mr, wl;
        eb = mk(0,0,0,0,2'b00,0,2'b00,0,1,0,0);
        mr = mk(1,0,0,0,2'b00,0,2'b00,0,1,0,0);
        wl = mk(0,0,0,1,2'b00,1,2'b01,0,1,0,0);
        s = '{SR, SY, SY, SY, SY, SW, SW, SY, SY, SY};
        e = '{ZZ, ZZ, FR, ZZ, eb, mr, mr, mr, wl, FR};
        for (int i = 0; i < s.size(); i++) begin
            cyc(s[i], OP_LW);
            vectors++;
            if (outs() !== e[i]) begin
                miscompares++;
                $display("[TB] FAIL load[%0d]: got %b, expected %b", i, outs(), e[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [2:0]  s[$];
        logic [13:0] e[$];
        for (int t = 1; t >= 0; t--) begin
            s = '{SR, SY, SY, SY, (t == 1) ? ST : SY, SY};
            e = '{ZZ, ZZ, FR, ZZ, mk(0,0,0,1,{1'b0, t[0]},0,2'b00,0,0,0,0), FR};
            for (int i = 0; i < s.size(); i++) begin
                cyc(s[i], OP_BEQ);
                vectors++;
                if (outs() !== e[i]) begin
                    miscompares++;
                    $display("[TB] FAIL branch taken=%0d [%0d]: got %b, expected %b", t, i, outs(), e[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  s[$];
        logic [6:0]  o[$];
        logic [13:0] e[$];
        logic [13:0] eb;
        eb = mk(0,0,0,0,2'b00,0,2'b00,0,1,0,0);
        s = '{SR, SY, SY, SY, SY, SY, SY, SY, ST, SY, SY, SY, SY, SY, SY};
        o = '{OP_SW, OP_SW, OP_SW, OP_SW, OP_SW, OP_SW, OP_BEQ, OP_BEQ, OP_BEQ,
              OP_LW, OP_LW, OP_LW, OP_LW, OP_LW, OP_LW};
        e = '{ZZ, ZZ, FR, ZZ, eb, mk(1,1,0,1,2'b00,0,2'b00,0,1,0,0),
              FR, ZZ, mk(0,0,0,1,2'b01,0,2'b00,0,0,0,0),
              FR, ZZ, eb, mk(1,0,0,0,2'b00,0,2'b00,0,1,0,0), mk(0,0,0,1,2'b00,1,2'b01,0,1,0,0), FR};
        for (int i = 0; i < s.size(); i++) begin
            cyc(s[i], o[i]);
            vectors++;
            if (outs() !== e[i]) begin
                miscompares++;
                $display("[TB] FAIL back_to_back[%0d]: got %b, expected %b", i, outs(), e[i]);
            end
        end
    endtask

    task automatic test_fetch_wait_limit();
        logic [2:0]  s[$];
        logic [13:0] e[$];
        s = '{SR, SW};
        e = '{ZZ, ZZ};
        for (int k = 0; k < 6; k++) begin
            s.push_back(SW);
            e.push_back(FW);
        end
        s.push_back(SY); e.push_back(FR);
        s.push_back(SY); e.push_back(ZZ);
        for (int i = 0; i < s.size(); i++) begin
            cyc(s[i], OP_ADD);
            vectors++;
            if (outs() !== e[i]) begin
                miscompares++;
                $display("[TB] FAIL fetch_wait6[%0d]: got %b, expected %b", i, outs(), e[i]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [2:0]  s[$];
        logic [13:0] e[$];
        s = '{SR, SW};
        e = '{ZZ, ZZ};
        for (int k = 0; k < 7; k++) begin
            s.push_back(SW);
            e.push_back(FW);
        end
        s.push_back(SW); e.push_back(HE);
        s.push_back(SY); e.push_back(HE);
        s.push_back(SR); e.push_back(ZZ);
        s.push_back(SY); e.push_back(ZZ);
        s.push_back(SY); e.push_back(FR);
        for (int i = 0; i < s.size(); i++) begin
            cyc(s[i], OP_ADD);
            vectors++;
            if (outs() !== e[i]) begin
                miscompares++;
                $display("[TB] FAIL timeout[%0d]: got %b, expected %b", i, outs(), e[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [6:0]  ops[2];
        logic [2:0]  s[$];
        logic [13:0] e[$];
        ops = '{7'b1111111, 7'b0001111};
        for (int k = 0; k < 2; k++) begin
            s = '{SR, SY, SY, SY, SY, SY, SY};
`ifdef ILLEGAL_OPCODE_TRAP_EN
            e = '{ZZ, ZZ, FR, ZZ, ZZ, HL, HL};
`else
            e = '{ZZ, ZZ, FR, ZZ, mk(0,0,0,1,2'b00,0,2'b00,0,0,0,0), FR, ZZ};
`endif
            for (int i = 0; i < s.size(); i++) begin
                cyc(s[i], ops[k]);
                vectors++;
                if (outs() !== e[i]) begin
                    miscompares++;
                    $display("[TB] FAIL illegal op=%b [%0d]: got %b, expected %b", ops[k], i, outs(), e[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_store();
        logic [2:0]  s[$];
        logic [13:0] e[$];
        s = '{SR, SY, SY, SY, SY, SW, SR, SW, SY};
        e = '{ZZ, ZZ, FR, ZZ, mk(0,0,0,0,2'b00,0,2'b00,0,1,0,0),
              mk(1,1,0,0,2'b00,0,2'b00,0,1,0,0), ZZ, ZZ, FR};
        for (int i = 0; i < s.size(); i++) begin
            cyc(s[i], OP_SW);
            vectors++;
            if (outs() !== e[i]) begin
                miscompares++;
                $display("[TB] FAIL reset_mid_store[%0d]: got %b, expected %b", i, outs(), e[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        opcode       = OP_ADD;
        ZZ = '0;
        FR = mk(1,0,1,0,2'b00,0,2'b00,0,0,0,0);
        FW = mk(1,0,0,0,2'b00,0,2'b00,0,0,0,0);
        HL = mk(0,0,0,0,2'b00,0,2'b00,0,0,1,0);
        HE = mk(0,0,0,0,2'b00,0,2'b00,0,0,1,1);

        test_reset();
        test_alu_class();
        test_load_wait();
        test_branch();
        test_back_to_back();
        test_fetch_wait_limit();
        test_timeout();
        test_illegal();
        test_reset_mid_store();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
